// File: rtl/bus_sync_pkg.sv
// Shared constants for the bus_sync source-side front end.
//   ST_IDLE / ST_HOLD / ST_GAP : transmit FSM state encodings
//   BUS_WIDTH_DEFAULT          : default data width, matches bus_sync
package bus_sync_pkg;

   localparam int unsigned BUS_WIDTH_DEFAULT = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

endpackage : bus_sync_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered occupancy count.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata (ignored when full)
//   pop      : drop the head word (ignored when empty)
//   wdata    : word to write
//   rdata    : current head word, combinational
//   full     : no free entry
//   empty    : no stored entry
//   level    : registered number of stored words
module sync_fifo #(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic                            pop,
   input  logic [BUS_WIDTH-1:0]            wdata,
   output logic [BUS_WIDTH-1:0]            rdata,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(FIFO_DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   // Same address with differing wrap bits means the writer lapped the reader.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Storage array; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + PW'(1);
            2'b01:   level <= level - PW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule : sync_fifo

// File: rtl/bus_sync_tx_ctrl.sv
// Source-domain front end for bus_sync: buffers producer words and emits each
// on tx_data with an EN pulse of fixed high time and a guaranteed low gap,
// keeping tx_data stable across the whole transfer.
//   clk, rst  : source clock, synchronous active-high reset
//   in_data   : producer word
//   in_valid  : producer word valid
//   in_ready  : FIFO can accept (not full, not in reset), combinational
//   tx_data   : registered word to bus_sync
//   EN        : registered enable to bus_sync
//   busy      : FSM active or words pending, combinational
//   level     : registered FIFO occupancy
module bus_sync_tx_ctrl
   import bus_sync_pkg::*;
#(
   parameter int unsigned BUS_WIDTH   = BUS_WIDTH_DEFAULT,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [BUS_WIDTH-1:0]            in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [BUS_WIDTH-1:0]            tx_data,
   output logic                            EN,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     level
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 en_nxt;
   logic [BUS_WIDTH-1:0] tx_data_nxt;
   logic                 pop;
   logic                 push;
   logic                 full;
   logic                 empty;
   logic [BUS_WIDTH-1:0] head;

   // Ready looks only at current occupancy, so a same-cycle pop never frees a slot.
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;
   assign busy     = (state != ST_IDLE) || !empty;

   sync_fifo #(
      .BUS_WIDTH  (BUS_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         EN      <= 1'b0;
         tx_data <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         EN      <= en_nxt;
         tx_data <= tx_data_nxt;
      end
   end

   // Next-state logic; a pop always coincides with loading tx_data and raising EN.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      en_nxt      = EN;
      tx_data_nxt = tx_data;
      pop         = 1'b0;

      case (state)
         ST_IDLE: begin
            en_nxt = 1'b0;
            if (!empty) begin
               pop         = 1'b1;
               tx_data_nxt = head;
               en_nxt      = 1'b1;
               cnt_nxt     = CNT_W'(HOLD_CYCLES - 1);
               state_nxt   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               en_nxt    = 1'b0;
               cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
               state_nxt = ST_GAP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else if (!empty) begin
               // Back-to-back word: skip IDLE to keep the period at HOLD+GAP.
               pop         = 1'b1;
               tx_data_nxt = head;
               en_nxt      = 1'b1;
               cnt_nxt     = CNT_W'(HOLD_CYCLES - 1);
               state_nxt   = ST_HOLD;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            en_nxt    = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule : bus_sync_tx_ctrl

// File: tb/tb_bus_sync_tx_ctrl.sv
// Directed bench for bus_sync_tx_ctrl with HOLD=2, GAP=2, DEPTH=4.
module tb_bus_sync_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       en;
   logic       busy;
   logic [2:0] level;

   int n_cmp = 0;
   int n_err = 0;

   bus_sync_tx_ctrl #(
      .BUS_WIDTH   (8),
      .FIFO_DEPTH  (4),
      .HOLD_CYCLES (2),
      .GAP_CYCLES  (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_data  (tx_data),
      .EN       (en),
      .busy     (busy),
      .level    (level)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_en, input logic [7:0] e_tx,
                            input logic [2:0] e_lvl, input logic e_rdy, input logic e_busy);
      check({tag, ".EN"},       32'(en),       32'(e_en));
      check({tag, ".tx_data"},  32'(tx_data),  32'(e_tx));
      check({tag, ".level"},    32'(level),    32'(e_lvl));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
      check({tag, ".busy"},     32'(busy),     32'(e_busy));
   endtask

   // Stream vectors, one entry per clock edge: stimulus before the edge,
   // expected outputs after it.
   logic       s_val [26];
   logic [7:0] s_din [26];
   logic       s_en  [26];
   logic [7:0] s_tx  [26];
   logic [2:0] s_lvl [26];
   logic       s_rdy [26];
   logic       s_bsy [26];

   // Reset-mid-transfer vectors.
   logic [7:0] r_din [6];
   logic       r_en  [6];
   logic [7:0] r_tx  [6];
   logic [2:0] r_lvl [6];

   initial begin
      s_val = '{1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      s_din = '{8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h06,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      s_en  = '{0,1,1,0,0,1,1,0,0,1,1,0,0,1,1,0,0,1,1,0,0,1,1,0,0,0};
      s_tx  = '{8'h99,8'h01,8'h01,8'h01,8'h01,8'h02,8'h02,8'h02,8'h02,8'h03,8'h03,8'h03,8'h03,
                8'h04,8'h04,8'h04,8'h04,8'h05,8'h05,8'h05,8'h05,8'h06,8'h06,8'h06,8'h06,8'h06};
      s_lvl = '{1,1,2,3,4,3,4,4,4,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0};
      s_rdy = '{1,1,1,1,0,1,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
      s_bsy = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};

      r_din = '{8'h11,8'hFF,8'hA1,8'hA2,8'hA3,8'hA3};
      r_en  = '{0,1,1,0,0,1};
      r_tx  = '{8'h06,8'h11,8'h11,8'h11,8'h11,8'hFF};
      r_lvl = '{1,1,2,3,4,3};

      // Reset values
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      step(); step(); step();
      check_all("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_all("post_reset", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);

      // Single word: EN high 2 cycles starting one cycle after the push
      in_valid = 1'b1; in_data = 8'h99;
      step();
      in_valid = 1'b0; in_data = 8'h00;
      check_all("single.push", 1'b0, 8'h00, 3'd1, 1'b1, 1'b1);
      step(); check_all("single.hold0", 1'b1, 8'h99, 3'd0, 1'b1, 1'b1);
      step(); check_all("single.hold1", 1'b1, 8'h99, 3'd0, 1'b1, 1'b1);
      step(); check_all("single.gap0",  1'b0, 8'h99, 3'd0, 1'b1, 1'b1);
      step(); check_all("single.gap1",  1'b0, 8'h99, 3'd0, 1'b1, 1'b1);
      step(); check_all("single.idle",  1'b0, 8'h99, 3'd0, 1'b1, 1'b0);

      // Back-to-back stream with full-FIFO refusal on the pop cycle
      for (int i = 0; i < 26; i++) begin
         in_valid = s_val[i];
         in_data  = s_din[i];
         step();
         check_all($sformatf("stream[%0d]", i), s_en[i], s_tx[i], s_lvl[i], s_rdy[i], s_bsy[i]);
      end

      // Reset mid-transfer: FF in HOLD with three words queued
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = r_din[i];
         step();
         check_all($sformatf("pre_rst[%0d]", i), r_en[i], r_tx[i], r_lvl[i],
                   1'(r_lvl[i] != 3'd4), 1'b1);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      check_all("mid_rst", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_all($sformatf("after_rst[%0d]", i), 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_bus_sync_tx_ctrl
